ray_sphere_multi: RTL

- Successor to the single-sphere ray-trace discriminant core.
- Tests one primary ray (pixel direction) against NUM_SPHERES spheres, one sphere per cycle, through a 4-stage discriminant pipeline.
- Returns a per-sphere hit mask, an any-hit flag and the lowest-index hit.
- Sits between the pixel generator (upstream valid/ready) and the shader/framebuffer writer (downstream valid/ready).

---
 rtl/rt_pkg.sv | 62 ++++++
 rtl/rs_disc_pipe.sv | 86 ++++++++
 rtl/ray_sphere_multi.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared widths, types and helpers for the multi-sphere ray tester
package rt_pkg;

  localparam int RT_COORD_W     = 11;
  localparam int RT_RADIUS_W    = 10;
  localparam int RT_NUM_SPHERES = 4;
  localparam int RT_TAG_W       = 20;
  localparam int RT_IDX_W       = (RT_NUM_SPHERES > 1) ? $clog2(RT_NUM_SPHERES) : 1;

  function automatic int a_w(input int w);
    return 2*w + 2;
  endfunction

  function automatic int b_w(input int w);
    return 2*w + 3;
  endfunction

  function automatic int c_w(input int w, input int rw);
    int p2;
    p2 = 2*w + 2;
    return ((p2 > 2*rw) ? p2 : 2*rw) + 1;
  endfunction

  function automatic int disc_w(input int w);
    return 4*w + 8;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic signed [RT_COORD_W-1:0] x;
    logic signed [RT_COORD_W-1:0] y;
    logic signed [RT_COORD_W-1:0] z;
    logic [RT_RADIUS_W-1:0]       r;
    logic                         en;
  } sphere_s;

  typedef struct packed {
    logic signed [RT_COORD_W-1:0] px;
    logic signed [RT_COORD_W-1:0] py;
    logic signed [RT_COORD_W-1:0] pz;
    logic [RT_TAG_W-1:0]          tag;
  } ray_req_s;

  typedef struct packed {
    logic [RT_TAG_W-1:0]       tag;
    logic [RT_NUM_SPHERES-1:0] hit_mask;
    logic                      hit_any;
    logic [RT_IDX_W-1:0]       first_idx;
  } ray_res_s;

  // Lowest set bit wins; an empty mask reports index 0.
  function automatic int first_set(input logic [15:0] mask);
    int idx;
    idx = 0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_disc_pipe.sv
// rtl/rs_disc_pipe.sv - 4-stage lossless ray/sphere discriminant pipeline, one sphere per cycle
module rs_disc_pipe
  import rt_pkg::*;
#(
  parameter int COORD_W  = RT_COORD_W,
  parameter int RADIUS_W = RT_RADIUS_W,
  parameter int IDX_W    = RT_IDX_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic                      en_i,
  input  logic signed [COORD_W-1:0] px_i,
  input  logic signed [COORD_W-1:0] py_i,
  input  logic signed [COORD_W-1:0] pz_i,
  input  logic signed [COORD_W-1:0] ox_i,
  input  logic signed [COORD_W-1:0] oy_i,
  input  logic signed [COORD_W-1:0] oz_i,
  input  logic [RADIUS_W-1:0]       r_i,
  output logic                      valid_o,
  output logic [IDX_W-1:0]          idx_o,
  output logic                      hit_o
);

  localparam int P   = 2*COORD_W;
  localparam int R2W = 2*RADIUS_W;
  localparam int AW  = a_w(COORD_W);
  localparam int BW  = b_w(COORD_W);
  localparam int CW  = c_w(COORD_W, RADIUS_W);
  localparam int DW  = disc_w(COORD_W);

  logic [3:0]              v_q;
  logic [IDX_W-1:0]        idx_q [4];
  logic [2:0]              en_q;
  logic signed [P-1:0]     pp_q [3];
  logic signed [P-1:0]     po_q [3];
  logic signed [P-1:0]     oo_q [3];
  logic [R2W-1:0]          rr_q;
  logic [AW-1:0]           a_q;
  logic signed [BW-1:0]    b_q;
  logic signed [CW-1:0]    c_q;
  logic signed [DW-1:0]    b2_q;
  logic signed [DW-1:0]    ac4_q;
  logic signed [DW-1:0]    disc_d;
  logic                    hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= {v_q[2:0], valid_i};
  end

  assign disc_d = b2_q - ac4_q;

  // Datapath carries no reset; only the valid chain qualifies it.
  always_ff @(posedge clk) begin
    idx_q[0] <= idx_i;
    for (int k = 1; k < 4; k++) idx_q[k] <= idx_q[k-1];
    en_q <= {en_q[1:0], en_i};

    pp_q[0] <= P'(px_i) * P'(px_i);
    pp_q[1] <= P'(py_i) * P'(py_i);
    pp_q[2] <= P'(pz_i) * P'(pz_i);
    po_q[0] <= P'(px_i) * P'(ox_i);
    po_q[1] <= P'(py_i) * P'(oy_i);
    po_q[2] <= P'(pz_i) * P'(oz_i);
    oo_q[0] <= P'(ox_i) * P'(ox_i);
    oo_q[1] <= P'(oy_i) * P'(oy_i);
    oo_q[2] <= P'(oz_i) * P'(oz_i);
    rr_q    <= R2W'(r_i) * R2W'(r_i);

    a_q <= AW'($unsigned(pp_q[0])) + AW'($unsigned(pp_q[1])) + AW'($unsigned(pp_q[2]));
    b_q <= (BW'(po_q[0]) + BW'(po_q[1]) + BW'(po_q[2])) <<< 1;
    c_q <= CW'(oo_q[0]) + CW'(oo_q[1]) + CW'(oo_q[2]) - CW'($signed({1'b0, rr_q}));

    b2_q  <= DW'(b_q) * DW'(b_q);
    ac4_q <= (DW'($signed({1'b0, a_q})) * DW'(c_q)) <<< 2;

    hit_q <= en_q[2] && !disc_d[DW-1];
  end

  assign valid_o = v_q[3];
  assign idx_o   = idx_q[3];
  assign hit_o   = hit_q;

endmodule

// File: rtl/ray_sphere_multi.sv
// rtl/ray_sphere_multi.sv - tests one primary ray against NUM_SPHERES spheres, returns hit mask
module ray_sphere_multi
  import rt_pkg::*;
#(
  parameter int COORD_W     = RT_COORD_W,
  parameter int RADIUS_W    = RT_RADIUS_W,
  parameter int NUM_SPHERES = RT_NUM_SPHERES,
  parameter int TAG_W       = RT_TAG_W,
  parameter int IW          = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [COORD_W-1:0]         in_px,
  input  logic signed [COORD_W-1:0]         in_py,
  input  logic signed [COORD_W-1:0]         in_pz,
  input  logic [TAG_W-1:0]                  in_tag,
  input  logic [NUM_SPHERES*COORD_W-1:0]    sph_x,
  input  logic [NUM_SPHERES*COORD_W-1:0]    sph_y,
  input  logic [NUM_SPHERES*COORD_W-1:0]    sph_z,
  input  logic [NUM_SPHERES*RADIUS_W-1:0]   sph_r,
  input  logic [NUM_SPHERES-1:0]            sph_en,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [TAG_W-1:0]                  out_tag,
  output logic [NUM_SPHERES-1:0]            out_hit_mask,
  output logic                              out_hit_any,
  output logic [IW-1:0]                     out_first_idx
);

  state_e                 state_q;
  logic [IW-1:0]          cnt_q;
  ray_req_s               req_q;
  sphere_s                snap_q [NUM_SPHERES];
  logic [NUM_SPHERES-1:0] mask_q;
  logic                   last_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  ray_res_s               res_q;
  sphere_s                cur_d;
  logic                   p_valid;
  logic [IW-1:0]          p_idx;
  logic                   p_hit;

  assign cur_d = snap_q[cnt_q];

  rs_disc_pipe #(.COORD_W(COORD_W), .RADIUS_W(RADIUS_W), .IDX_W(IW)) u_pipe (
    .clk(clk), .rst_n(rst_n),
    .valid_i(state_q == S_ISSUE), .idx_i(cnt_q), .en_i(cur_d.en),
    .px_i(req_q.px), .py_i(req_q.py), .pz_i(req_q.pz),
    .ox_i(cur_d.x), .oy_i(cur_d.y), .oz_i(cur_d.z), .r_i(cur_d.r),
    .valid_o(p_valid), .idx_o(p_idx), .hit_o(p_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      for (int i = 0; i < NUM_SPHERES; i++) snap_q[i] <= '0;
      mask_q      <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      last_q <= 1'b0;
      if (p_valid) begin
        mask_q[p_idx] <= p_hit;
        if (p_idx == IW'(NUM_SPHERES-1)) last_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: if (in_valid && in_ready_q) begin
          req_q <= '{px: in_px, py: in_py, pz: in_pz, tag: in_tag};
          for (int i = 0; i < NUM_SPHERES; i++) begin
            snap_q[i] <= '{x:  $signed(sph_x[i*COORD_W +: COORD_W]),
                           y:  $signed(sph_y[i*COORD_W +: COORD_W]),
                           z:  $signed(sph_z[i*COORD_W +: COORD_W]),
                           r:  sph_r[i*RADIUS_W +: RADIUS_W],
                           en: sph_en[i]};
          end
          mask_q     <= '0;
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
          state_q    <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt_q <= IW'(cnt_q + 1'b1);
          if (cnt_q == IW'(NUM_SPHERES-1)) state_q <= S_DRAIN;
        end
        // last_q lags the final pipe result by one cycle so mask_q is complete here.
        S_DRAIN: if (last_q) begin
          res_q.tag       <= req_q.tag;
          res_q.hit_mask  <= mask_q;
          res_q.hit_any   <= |mask_q;
          res_q.first_idx <= IW'(first_set(16'(mask_q)));
          out_valid_q     <= 1'b1;
          state_q         <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_tag       = res_q.tag;
  assign out_hit_mask  = res_q.hit_mask;
  assign out_hit_any   = res_q.hit_any;
  assign out_first_idx = res_q.first_idx;

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid &&
      $stable({out_tag, out_hit_mask, out_hit_any, out_first_idx})));
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_valid && in_ready && out_valid));
  a_any_or: assert property (@(posedge clk) disable iff (!rst_n)
    out_hit_any == |out_hit_mask);

endmodule
